fetch_ctrl: RTL and testbench

//  Front-end pipeline controller sequencing the instruction-fetch stage and IF/ID register.

---
 rtl/fetch_ctrl_pkg.sv | 22 ++
 rtl/fetch_ctrl_if.sv | 44 ++++
 rtl/fetch_ctrl_lu_hazard.sv | 23 ++
 rtl/fetch_ctrl.sv | 152 +++++++++++++++
 tb/tb_fetch_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the fetch-stage controller.
//   fctrl_state_t : controller state encoding
//   NOP_INSN      : instruction the fetch unit presents to ID while issue_nop=1
//   FCNT_W        : width of the post-redirect flush down-counter
//   align_pc()    : clears bits[1:0] of a redirect target
package fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        FLUSH    = 2'd1,
        MEM_WAIT = 2'd2,
        HALTED   = 2'd3
    } fctrl_state_t;

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;
    localparam int          FCNT_W   = 4;

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Bundle between the pipeline datapath and the fetch controller.
//   master : pipeline side, drives hazard/redirect/memory/halt status, reads controls
//   slave  : fetch_ctrl side, reads status, drives stall/issue_nop/jmp/jmp_pc,
//            ex_bubble/flush_id/halted and the stall/flush performance counters
interface fetch_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_rs1_used;
    logic             id_rs2_used;
    logic [4:0]       ex_rd;
    logic             ex_mem_read;
    logic             br_taken;
    logic [31:0]      br_target;
    logic             dmem_busy;
    logic             halt_req;
    logic             resume;

    logic             stall;
    logic             issue_nop;
    logic             jmp;
    logic [31:0]      jmp_pc;
    logic             ex_bubble;
    logic             flush_id;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd, ex_mem_read,
               br_taken, br_target, dmem_busy, halt_req, resume,
        input  stall, issue_nop, jmp, jmp_pc, ex_bubble, flush_id, halted,
               stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd, ex_mem_read,
               br_taken, br_target, dmem_busy, halt_req, resume,
        output stall, issue_nop, jmp, jmp_pc, ex_bubble, flush_id, halted,
               stall_cnt, flush_cnt
    );

endinterface

// File: rtl/fetch_ctrl_lu_hazard.sv
// Load-use hazard detector: flags an ID instruction that reads the destination of
// a load currently in EX. x0 is never a real dependency.
//   id_rs1/id_rs2, id_rs1_used/id_rs2_used : source registers of the ID instruction
//   ex_rd, ex_mem_read                    : destination and load flag of the EX instruction
//   lu_hit                                : hazard present (combinational)
module lu_hazard (
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_rs1_used,
    input  logic       id_rs2_used,
    input  logic [4:0] ex_rd,
    input  logic       ex_mem_read,
    output logic       lu_hit
);

    logic rs1_match;
    logic rs2_match;

    assign rs1_match = id_rs1_used && (id_rs1 == ex_rd);
    assign rs2_match = id_rs2_used && (id_rs2 == ex_rd);
    assign lu_hit    = ex_mem_read && (ex_rd != 5'd0) && (rs1_match || rs2_match);

endmodule

// File: rtl/fetch_ctrl.sv
// Front-end pipeline controller for the instruction-fetch stage and IF/ID register.
// Merges load-use hazards, EX-stage redirects, data-memory wait and halt/resume into
// the fetch controls, and keeps wrap-around stall and redirect counters.
//   clk, reset : clock, synchronous active-high reset
//   bus        : fetch_ctrl_if.slave (status in; stall/issue_nop/jmp/jmp_pc,
//                ex_bubble/flush_id/halted, stall_cnt/flush_cnt out)
// Parameters: FLUSH_CYCLES (1..15) issue_nop cycles after a redirect; CNT_W counter width.
//
// state    | meaning
// RUN      | normal fetch; evaluates busy > redirect > load-use > halt
// FLUSH    | wrong-path slots after a redirect; ID is fed NOPs for fcnt cycles
// MEM_WAIT | data memory busy; whole pipe frozen, EX events re-presented later
// HALTED   | pipe held until resume
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input logic         clk,
    input logic         reset,
    fetch_ctrl_if.slave bus
);

    localparam logic [FCNT_W-1:0] FLUSH_LOAD = FCNT_W'(FLUSH_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    fctrl_state_t      state_q, state_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic [31:0]       jmp_pc_q;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic [CNT_W-1:0]  flush_cnt_q;

    logic lu_hit;
    logic stall_c, nop_c, jmp_c, bubble_c, flush_c, halted_c;

    lu_hazard u_lu_hazard (
        .id_rs1      (bus.id_rs1),
        .id_rs2      (bus.id_rs2),
        .id_rs1_used (bus.id_rs1_used),
        .id_rs2_used (bus.id_rs2_used),
        .ex_rd       (bus.ex_rd),
        .ex_mem_read (bus.ex_mem_read),
        .lu_hit      (lu_hit)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            fcnt_q      <= '0;
            jmp_pc_q    <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            if (jmp_c) begin
                jmp_pc_q    <= align_pc(bus.br_target);
                flush_cnt_q <= flush_cnt_q + CNT_ONE;
            end
            if (stall_c) begin
                stall_cnt_q <= stall_cnt_q + CNT_ONE;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        fcnt_d   = fcnt_q;
        stall_c  = 1'b0;
        nop_c    = 1'b0;
        jmp_c    = 1'b0;
        bubble_c = 1'b0;
        flush_c  = 1'b0;
        halted_c = 1'b0;

        case (state_q)
            // MEM_WAIT with the memory ready behaves exactly like RUN, so the
            // deferred EX events are acted on in the cycle the freeze lifts.
            RUN, MEM_WAIT: begin
                if (bus.dmem_busy) begin
                    stall_c = 1'b1;
                    state_d = MEM_WAIT;
                end else if (bus.br_taken) begin
                    jmp_c   = 1'b1;
                    flush_c = 1'b1;
                    fcnt_d  = FLUSH_LOAD;
                    state_d = FLUSH;
                end else if (lu_hit) begin
                    stall_c  = 1'b1;
                    bubble_c = 1'b1;
                    state_d  = RUN;
                end else if (bus.halt_req) begin
                    stall_c = 1'b1;
                    state_d = HALTED;
                end else begin
                    state_d = RUN;
                end
            end
            // ID holds a NOP here, so load-use is moot; halt_req is a level and
            // is picked up once the flush drains. A busy memory freezes the
            // flush countdown rather than dropping the remaining NOP slots.
            FLUSH: begin
                nop_c = 1'b1;
                if (bus.dmem_busy) begin
                    stall_c = 1'b1;
                end else if (bus.br_taken) begin
                    jmp_c   = 1'b1;
                    flush_c = 1'b1;
                    fcnt_d  = FLUSH_LOAD;
                end else if (fcnt_q <= 1) begin
                    fcnt_d  = '0;
                    state_d = RUN;
                end else begin
                    fcnt_d = fcnt_q - 1'b1;
                end
            end
            HALTED: begin
                stall_c  = 1'b1;
                halted_c = 1'b1;
                if (bus.resume) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
                fcnt_d  = '0;
            end
        endcase

        // Controls read as idle for the whole reset cycle regardless of state.
        if (reset) begin
            stall_c  = 1'b0;
            nop_c    = 1'b0;
            jmp_c    = 1'b0;
            bubble_c = 1'b0;
            flush_c  = 1'b0;
            halted_c = 1'b0;
        end
    end

    assign bus.stall     = stall_c;
    assign bus.issue_nop = nop_c;
    assign bus.jmp       = jmp_c;
    assign bus.jmp_pc    = reset ? 32'd0 : (jmp_c ? align_pc(bus.br_target) : jmp_pc_q);
    assign bus.ex_bubble = bubble_c;
    assign bus.flush_id  = flush_c;
    assign bus.halted    = halted_c;
    assign bus.stall_cnt = stall_cnt_q;
    assign bus.flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios with constant expectations, then a long
// randomized run checked against a cycle model of the controller's rules.
module tb_fetch_ctrl;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   passes = 0;

    always #5 clk = ~clk;

    fetch_ctrl_if #(.CNT_W(32)) bus ();

    fetch_ctrl #(.FLUSH_CYCLES(2), .CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // {stall, issue_nop, jmp, ex_bubble, flush_id, halted}
    function automatic logic [5:0] outs();
        return {bus.stall, bus.issue_nop, bus.jmp, bus.ex_bubble, bus.flush_id, bus.halted};
    endfunction

    task automatic idle();
        bus.id_rs1 = 5'd0;       bus.id_rs2 = 5'd0;
        bus.id_rs1_used = 1'b0;  bus.id_rs2_used = 1'b0;
        bus.ex_rd = 5'd0;        bus.ex_mem_read = 1'b0;
        bus.br_taken = 1'b0;     bus.br_target = 32'd0;
        bus.dmem_busy = 1'b0;    bus.halt_req = 1'b0;
        bus.resume = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        step();
        step();
        reset = 1'b0;
        @(negedge clk);
        checks++; if (outs() !== 6'b0) $display("FAIL reset_outs: got %b want 000000", outs()); else passes++;
        checks++; if (bus.jmp_pc !== 32'd0) $display("FAIL reset_jmp_pc: got %h want 0", bus.jmp_pc); else passes++;
        checks++; if (bus.stall_cnt !== 32'd0 || bus.flush_cnt !== 32'd0)
            $display("FAIL reset_cnt: got %0d/%0d want 0/0", bus.stall_cnt, bus.flush_cnt); else passes++;
        step();
    endtask

    task automatic test_load_use();
        do_reset();
        bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd5; bus.id_rs1 = 5'd5; bus.id_rs1_used = 1'b1;
        @(negedge clk);
        checks++; if (outs() !== 6'b100100) $display("FAIL lu_rs1: got %b want 100100", outs()); else passes++;
        step();
        idle();
        @(negedge clk);
        checks++; if (outs() !== 6'b0) $display("FAIL lu_one_cycle: got %b want 000000", outs()); else passes++;
        checks++; if (bus.stall_cnt !== 32'd1) $display("FAIL lu_stall_cnt: got %0d want 1", bus.stall_cnt); else passes++;
        bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd0; bus.id_rs1 = 5'd0; bus.id_rs1_used = 1'b1;
        @(negedge clk);
        checks++; if (outs() !== 6'b0) $display("FAIL lu_x0: got %b want 000000", outs()); else passes++;
        step();
        bus.ex_rd = 5'd7; bus.id_rs1 = 5'd3; bus.id_rs2 = 5'd7; bus.id_rs2_used = 1'b1;
        @(negedge clk);
        checks++; if (outs() !== 6'b100100) $display("FAIL lu_rs2: got %b want 100100", outs()); else passes++;
        step();
        bus.id_rs2_used = 1'b0;
        @(negedge clk);
        checks++; if (outs() !== 6'b0) $display("FAIL lu_unused: got %b want 000000", outs()); else passes++;
        step();
        idle();
        @(negedge clk);
        checks++; if (bus.stall_cnt !== 32'd2) $display("FAIL lu_stall_cnt2: got %0d want 2", bus.stall_cnt); else passes++;
    endtask

    task automatic test_branch();
        do_reset();
        bus.br_taken = 1'b1; bus.br_target = 32'h200;
        @(negedge clk);
        checks++; if (outs() !== 6'b001010) $display("FAIL br_redirect: got %b want 001010", outs()); else passes++;
        checks++; if (bus.jmp_pc !== 32'h200) $display("FAIL br_jmp_pc: got %h want 200", bus.jmp_pc); else passes++;
        step();
        idle();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++; if (outs() !== 6'b010000) $display("FAIL br_nop%0d: got %b want 010000", i, outs()); else passes++;
            step();
        end
        @(negedge clk);
        checks++; if (outs() !== 6'b0) $display("FAIL br_done: got %b want 000000", outs()); else passes++;
        checks++; if (bus.jmp_pc !== 32'h200) $display("FAIL br_pc_hold: got %h want 200", bus.jmp_pc); else passes++;
        checks++; if (bus.flush_cnt !== 32'd1) $display("FAIL br_flush_cnt: got %0d want 1", bus.flush_cnt); else passes++;
    endtask

    task automatic test_mem_wait();
        do_reset();
        bus.dmem_busy = 1'b1; bus.br_taken = 1'b1; bus.br_target = 32'h403;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (outs() !== 6'b100000) $display("FAIL mw_busy%0d: got %b want 100000", i, outs()); else passes++;
            step();
        end
        bus.dmem_busy = 1'b0;
        @(negedge clk);
        checks++; if (outs() !== 6'b001010) $display("FAIL mw_release: got %b want 001010", outs()); else passes++;
        checks++; if (bus.jmp_pc !== 32'h400) $display("FAIL mw_jmp_pc: got %h want 400", bus.jmp_pc); else passes++;
        checks++; if (bus.stall_cnt !== 32'd3) $display("FAIL mw_stall_cnt: got %0d want 3", bus.stall_cnt); else passes++;
        step();
        idle();
    endtask

    task automatic test_back_to_back();
        do_reset();
        bus.br_taken = 1'b1; bus.br_target = 32'h200;
        step();
        bus.br_target = 32'h300;
        @(negedge clk);
        checks++; if (outs() !== 6'b011010) $display("FAIL b2b_redirect: got %b want 011010", outs()); else passes++;
        checks++; if (bus.jmp_pc !== 32'h300) $display("FAIL b2b_jmp_pc: got %h want 300", bus.jmp_pc); else passes++;
        step();
        idle();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++; if (outs() !== 6'b010000) $display("FAIL b2b_nop%0d: got %b want 010000", i, outs()); else passes++;
            step();
        end
        @(negedge clk);
        checks++; if (outs() !== 6'b0) $display("FAIL b2b_done: got %b want 000000", outs()); else passes++;
        checks++; if (bus.flush_cnt !== 32'd2) $display("FAIL b2b_flush_cnt: got %0d want 2", bus.flush_cnt); else passes++;
    endtask

    task automatic test_halt();
        do_reset();
        bus.halt_req = 1'b1;
        @(negedge clk);
        checks++; if (outs() !== 6'b100000) $display("FAIL halt_enter: got %b want 100000", outs()); else passes++;
        step();
        bus.halt_req = 1'b0;
        bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd9; bus.id_rs1 = 5'd9; bus.id_rs1_used = 1'b1;
        bus.dmem_busy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++; if (outs() !== 6'b100001) $display("FAIL halt_hold%0d: got %b want 100001", i, outs()); else passes++;
            step();
        end
        idle();
        bus.resume = 1'b1;
        @(negedge clk);
        checks++; if (outs() !== 6'b100001) $display("FAIL halt_resume: got %b want 100001", outs()); else passes++;
        step();
        bus.resume = 1'b0;
        @(negedge clk);
        checks++; if (outs() !== 6'b0) $display("FAIL halt_exit: got %b want 000000", outs()); else passes++;
        checks++; if (bus.stall_cnt !== 32'd12) $display("FAIL halt_stall_cnt: got %0d want 12", bus.stall_cnt); else passes++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.br_taken = 1'b1; bus.br_target = 32'h500;
        step();
        idle();
        reset = 1'b1;
        @(negedge clk);
        checks++; if (outs() !== 6'b0) $display("FAIL rst_flush_during: got %b want 000000", outs()); else passes++;
        step();
        reset = 1'b0;
        @(negedge clk);
        checks++; if (outs() !== 6'b0 || bus.jmp_pc !== 32'd0) $display("FAIL rst_flush_after: got %b/%h want 000000/0", outs(), bus.jmp_pc); else passes++;
        checks++; if (bus.flush_cnt !== 32'd0) $display("FAIL rst_flush_cnt: got %0d want 0", bus.flush_cnt); else passes++;
        bus.halt_req = 1'b1;
        step();
        bus.halt_req = 1'b0;
        step();
        @(negedge clk);
        checks++; if (outs() !== 6'b100001) $display("FAIL rst_halt_pre: got %b want 100001", outs()); else passes++;
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        checks++; if (outs() !== 6'b0) $display("FAIL rst_halt_after: got %b want 000000", outs()); else passes++;
        checks++; if (bus.stall_cnt !== 32'd0) $display("FAIL rst_halt_cnt: got %0d want 0", bus.stall_cnt); else passes++;
        bus.dmem_busy = 1'b1;
        step();
        bus.dmem_busy = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        checks++; if (outs() !== 6'b0 || bus.stall_cnt !== 32'd0)
            $display("FAIL rst_memwait: got %b/%0d want 000000/0", outs(), bus.stall_cnt); else passes++;
    endtask

    // Model: the pipe is either halted, draining nops_left NOP slots after a
    // redirect, or running. A busy memory with nothing else pending is
    // indistinguishable from running, so it needs no state of its own.
    task automatic test_random();
        bit          m_halt;
        int          nops_left;
        logic [31:0] m_pc, m_scnt, m_fcnt;
        bit          r_rst, r_busy, r_br, r_halt, r_res, r_mr, r_u1, r_u2, lu;
        logic [4:0]  r_rd, r_r1, r_r2;
        logic [31:0] r_tgt, e_pc;
        logic [5:0]  e;
        bit          e_stall, e_nop, e_jmp, e_bub, e_fl, e_hlt;

        do_reset();
        m_halt = 0; nops_left = 0; m_pc = 0; m_scnt = 0; m_fcnt = 0;
        for (int n = 0; n < 3000; n++) begin
            r_rst  = ($urandom_range(0, 249) == 0);
            r_busy = ($urandom_range(0, 4) == 0);
            r_br   = ($urandom_range(0, 5) == 0);
            r_halt = ($urandom_range(0, 15) == 0);
            r_res  = ($urandom_range(0, 3) == 0);
            r_mr   = $urandom_range(0, 1);
            r_u1   = $urandom_range(0, 1);
            r_u2   = $urandom_range(0, 1);
            r_rd   = 5'($urandom_range(0, 3));
            r_r1   = 5'($urandom_range(0, 3));
            r_r2   = 5'($urandom_range(0, 3));
            r_tgt  = $urandom;

            reset = r_rst;
            bus.dmem_busy = r_busy; bus.br_taken = r_br; bus.br_target = r_tgt;
            bus.halt_req = r_halt;  bus.resume = r_res;
            bus.ex_mem_read = r_mr; bus.ex_rd = r_rd;
            bus.id_rs1 = r_r1; bus.id_rs2 = r_r2; bus.id_rs1_used = r_u1; bus.id_rs2_used = r_u2;

            lu = r_mr && (r_rd != 0) && ((r_u1 && r_r1 == r_rd) || (r_u2 && r_r2 == r_rd));
            e_stall = 0; e_nop = 0; e_jmp = 0; e_bub = 0; e_fl = 0; e_hlt = 0;
            if (!r_rst) begin
                if (m_halt) begin
                    e_stall = 1; e_hlt = 1;
                end else if (nops_left > 0) begin
                    e_nop = 1;
                    if (r_busy) e_stall = 1;
                    else if (r_br) begin e_jmp = 1; e_fl = 1; end
                end else begin
                    if (r_busy) e_stall = 1;
                    else if (r_br) begin e_jmp = 1; e_fl = 1; end
                    else if (lu) begin e_stall = 1; e_bub = 1; end
                    else if (r_halt) e_stall = 1;
                end
            end
            e    = {e_stall, e_nop, e_jmp, e_bub, e_fl, e_hlt};
            e_pc = r_rst ? 32'd0 : (e_jmp ? (r_tgt & 32'hFFFF_FFFC) : m_pc);

            @(negedge clk);
            checks++; if (outs() !== e) $display("FAIL rnd_outs@%0d: got %b want %b", n, outs(), e); else passes++;
            checks++; if (bus.jmp_pc !== e_pc) $display("FAIL rnd_jmp_pc@%0d: got %h want %h", n, bus.jmp_pc, e_pc); else passes++;
            checks++; if (bus.stall_cnt !== m_scnt || bus.flush_cnt !== m_fcnt)
                $display("FAIL rnd_cnt@%0d: got %0d/%0d want %0d/%0d", n, bus.stall_cnt, bus.flush_cnt, m_scnt, m_fcnt);
            else passes++;
            step();

            if (r_rst) begin
                m_halt = 0; nops_left = 0; m_pc = 0; m_scnt = 0; m_fcnt = 0;
            end else begin
                if (e_stall) m_scnt = m_scnt + 1;
                if (e_jmp) begin
                    m_fcnt = m_fcnt + 1;
                    m_pc = r_tgt & 32'hFFFF_FFFC;
                    nops_left = 2;
                end else if (m_halt) begin
                    if (r_res) m_halt = 0;
                end else if (nops_left > 0) begin
                    if (!r_busy) nops_left = nops_left - 1;
                end else if (!r_busy && !lu && r_halt) begin
                    m_halt = 1;
                end
            end
        end
        reset = 1'b0;
        idle();
    endtask

    initial begin
        reset = 1'b1;
        idle();
        test_reset();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_back_to_back();
        test_halt();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
